// File: rtl/vram_arbiter_if.sv
// Video RAM arbitration bus: requests and write flags from the video fetch,
// CPU and blitter, and the grants, mux select and strobes returned by the arbiter.
interface vram_arbiter_if;
    logic       VID_REQ;
    logic       CPU_REQ;
    logic       CPU_WR;
    logic       BLT_REQ;
    logic       BLT_WR;
    logic       VID_GNT;
    logic       CPU_GNT;
    logic       BLT_GNT;
    logic [1:0] SEL;
    logic       _WE;
    logic       ACK;
    logic       _WAIT;

    // Requester side: video timing chain, CPU bus interface and blitter.
    modport master (
        output VID_REQ, CPU_REQ, CPU_WR, BLT_REQ, BLT_WR,
        input  VID_GNT, CPU_GNT, BLT_GNT, SEL, _WE, ACK, _WAIT
    );

    // Arbiter side.
    modport slave (
        input  VID_REQ, CPU_REQ, CPU_WR, BLT_REQ, BLT_WR,
        output VID_GNT, CPU_GNT, BLT_GNT, SEL, _WE, ACK, _WAIT
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shared video RAM arbiter: video fetch has absolute priority, CPU and blitter
// share the remaining slots round-robin. Each access lasts ACC_CYC cycles,
// optionally followed by one dead cycle when TURN=1.
module vram_arbiter #(
    parameter int unsigned ACC_CYC = 2,
    parameter int unsigned TURN    = 1
) (
    input  logic           CLK,
    input  logic           _CLR,
    vram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RECOVER
    } state_t;

    // Owner encoding doubles as the RAM mux select value.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_VID  = 2'b01,
        OWN_CPU  = 2'b10,
        OWN_BLT  = 2'b11
    } owner_t;

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYC);
    localparam bit         HAS_TURN = (TURN != 0);

    state_t     state;
    logic [3:0] cnt;
    owner_t     last;
    logic       wr_q;

    owner_t     pick;
    logic       pick_wr;
    logic       cpu_live;
    logic       blt_live;
    logic       at_last;
    logic       decide;

    // Winner for the next decision edge; a requester just ACKed is treated as stale.
    always_comb begin
        cpu_live = bus.CPU_REQ && !(bus.ACK && bus.CPU_GNT);
        blt_live = bus.BLT_REQ && !(bus.ACK && bus.BLT_GNT);
        at_last  = (state == ST_ACCESS) && (cnt == CNT_LAST);
        decide   = (state == ST_IDLE) || (state == ST_RECOVER) || (at_last && !HAS_TURN);
        pick     = OWN_NONE;
        pick_wr  = 1'b0;
        if (bus.VID_REQ) begin
            pick = OWN_VID;
        end else if (cpu_live && blt_live) begin
            pick = (last == OWN_BLT) ? OWN_CPU : OWN_BLT;
        end else if (cpu_live) begin
            pick = OWN_CPU;
        end else if (blt_live) begin
            pick = OWN_BLT;
        end
        if (pick == OWN_CPU) begin
            pick_wr = bus.CPU_WR;
        end else if (pick == OWN_BLT) begin
            pick_wr = bus.BLT_WR;
        end
    end

    // Access sequencer with registered grants, select, ACK and write strobe.
    always_ff @(posedge CLK or negedge _CLR) begin
        if (!_CLR) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last        <= OWN_BLT;
            wr_q        <= 1'b0;
            bus.VID_GNT <= 1'b0;
            bus.CPU_GNT <= 1'b0;
            bus.BLT_GNT <= 1'b0;
            bus.SEL     <= OWN_NONE;
            bus._WE     <= 1'b1;
            bus.ACK     <= 1'b0;
        end else if (decide) begin
            if (pick != OWN_NONE) begin
                state       <= ST_ACCESS;
                cnt         <= 4'd1;
                wr_q        <= pick_wr;
                bus.VID_GNT <= (pick == OWN_VID);
                bus.CPU_GNT <= (pick == OWN_CPU);
                bus.BLT_GNT <= (pick == OWN_BLT);
                bus.SEL     <= pick;
                bus.ACK     <= (CNT_LAST == 4'd1);
                bus._WE     <= !(pick_wr && (CNT_LAST == 4'd1));
                if (pick == OWN_CPU || pick == OWN_BLT) begin
                    last <= pick;
                end
            end else begin
                state       <= ST_IDLE;
                cnt         <= '0;
                wr_q        <= 1'b0;
                bus.VID_GNT <= 1'b0;
                bus.CPU_GNT <= 1'b0;
                bus.BLT_GNT <= 1'b0;
                bus.SEL     <= OWN_NONE;
                bus.ACK     <= 1'b0;
                bus._WE     <= 1'b1;
            end
        end else if (at_last) begin
            state       <= ST_RECOVER;
            cnt         <= '0;
            wr_q        <= 1'b0;
            bus.VID_GNT <= 1'b0;
            bus.CPU_GNT <= 1'b0;
            bus.BLT_GNT <= 1'b0;
            bus.SEL     <= OWN_NONE;
            bus.ACK     <= 1'b0;
            bus._WE     <= 1'b1;
        end else if (state == ST_ACCESS) begin
            cnt     <= cnt + 4'd1;
            bus.ACK <= ((cnt + 4'd1) == CNT_LAST);
            bus._WE <= !(wr_q && ((cnt + 4'd1) == CNT_LAST));
        end
    end

    // Z80 wait is released combinationally in the CPU's ACK cycle.
    assign bus._WAIT = !(bus.CPU_REQ && !(bus.CPU_GNT && bus.ACK));

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: four parameter sets share one stimulus
// stream; a slot-schedule model pushes expected accesses, a monitor checks outputs.
module tb_vram_arbiter;

    localparam int NC = 4;

    function automatic int unsigned acc_of(int g);
        case (g)
            0: return 2;
            1: return 2;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned turn_of(int g);
        case (g)
            0: return 1;
            1: return 0;
            2: return 0;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic vid_req = 1'b0;
    logic cpu_req = 1'b0;
    logic cpu_wr = 1'b0;
    logic blt_req = 1'b0;
    logic blt_wr = 1'b0;

    logic [NC-1:0] o_vg, o_cg, o_bg, o_we_n, o_ack, o_wait_n;
    logic [1:0]    o_sel [NC];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        vram_arbiter_if bus ();
        assign bus.VID_REQ = vid_req;
        assign bus.CPU_REQ = cpu_req;
        assign bus.CPU_WR  = cpu_wr;
        assign bus.BLT_REQ = blt_req;
        assign bus.BLT_WR  = blt_wr;
        assign o_vg[g]     = bus.VID_GNT;
        assign o_cg[g]     = bus.CPU_GNT;
        assign o_bg[g]     = bus.BLT_GNT;
        assign o_sel[g]    = bus.SEL;
        assign o_we_n[g]   = bus._WE;
        assign o_ack[g]    = bus.ACK;
        assign o_wait_n[g] = bus._WAIT;

        vram_arbiter #(.ACC_CYC(acc_of(g)), .TURN(turn_of(g))) dut (
            .CLK  (clk),
            ._CLR (clr_n),
            .bus  (bus.slave)
        );
    end

    // who: 1 video, 2 CPU, 3 blitter (same values the mux select should show)
    typedef struct {
        int cfg;
        int who;
        bit wr;
        int start;
    } txn_t;

    txn_t sbq[$];

    int edge_n = 0;
    int checks = 0;
    int failures = 0;
    int next_dec [NC];
    int ack_end  [NC];
    int ack_who  [NC];
    int last_rr  [NC];

    // Slot schedule: a grant at edge E owns edges E..E+A-1, the next decision
    // is at E+A+TURN, and a requester whose slot ended exactly at the decision is stale.
    task automatic model_step();
        for (int i = 0; i < NC; i++) begin
            int a;
            int t;
            bit c;
            bit b;
            int who;
            bit wr;
            a = int'(acc_of(i));
            t = int'(turn_of(i));
            if (!clr_n) begin
                next_dec[i] = edge_n + 1;
                ack_end[i]  = -1;
                ack_who[i]  = 0;
                last_rr[i]  = 3;
            end else if (edge_n >= next_dec[i]) begin
                c = cpu_req && !(ack_end[i] == edge_n && ack_who[i] == 2);
                b = blt_req && !(ack_end[i] == edge_n && ack_who[i] == 3);
                who = 0;
                if (vid_req) who = 1;
                else if (c && b) who = (last_rr[i] == 3) ? 2 : 3;
                else if (c) who = 2;
                else if (b) who = 3;
                if (who != 0) begin
                    wr = (who == 2) ? cpu_wr : (who == 3) ? blt_wr : 1'b0;
                    sbq.push_back('{i, who, wr, edge_n});
                    if (who >= 2) last_rr[i] = who;
                    ack_end[i]  = edge_n + a;
                    ack_who[i]  = who;
                    next_dec[i] = edge_n + a + t;
                end else begin
                    next_dec[i] = edge_n + 1;
                end
            end
        end
        if (!clr_n) sbq.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_step();
        #1;
    endtask

    task automatic set_req(input bit v, input bit c, input bit cw, input bit b, input bit bw);
        vid_req = v;
        cpu_req = c;
        cpu_wr  = cw;
        blt_req = b;
        blt_wr  = bw;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Monitor: compare each instance's outputs with the scoreboard head for that instance.
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            logic [8:0] expv;
            logic [8:0] actv;
            int j;
            int a;
            bit fin;
            a = int'(acc_of(i));
            actv = {o_vg[i], o_cg[i], o_bg[i], o_sel[i], o_we_n[i], o_ack[i], o_wait_n[i]};
            expv = {3'b000, 2'b00, 1'b1, 1'b0, !cpu_req};
            if (clr_n) begin
                j = -1;
                for (int q = 0; q < sbq.size(); q++) begin
                    if (j < 0 && sbq[q].cfg == i) j = q;
                end
                if (j >= 0 && edge_n >= sbq[j].start && edge_n <= sbq[j].start + a - 1) begin
                    fin = (edge_n == sbq[j].start + a - 1);
                    expv = {sbq[j].who == 1, sbq[j].who == 2, sbq[j].who == 3, 2'(sbq[j].who),
                            !(sbq[j].wr && fin), fin,
                            !(cpu_req && !(sbq[j].who == 2 && fin))};
                    if (fin || o_ack[i]) sbq.delete(j);
                end
            end
            checks++;
            if (actv !== expv) begin
                failures++;
                $display("FAIL outputs cfg=%0d cycle=%0d got{vg,cg,bg,sel,we_n,ack,wait_n}=%b required=%b",
                         i, edge_n, actv, expv);
            end
        end
    end

    initial begin
        for (int i = 0; i < NC; i++) begin
            next_dec[i] = 0;
            ack_end[i]  = -1;
            ack_who[i]  = 0;
            last_rr[i]  = 3;
        end
        set_req(0, 0, 0, 0, 0);
        clr_n = 1'b0;
        ticks(3);
        clr_n = 1'b1;
        ticks(2);

        // Single CPU write.
        set_req(0, 1, 1, 0, 0);
        ticks(2);
        set_req(0, 0, 0, 0, 0);
        ticks(8);

        // CPU and blitter requesting continuously.
        for (int k = 0; k < 16; k++) begin
            set_req(0, 1, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1);
            tick();
        end
        set_req(0, 0, 0, 0, 0);
        ticks(8);

        // Blitter access, then video and CPU arrive mid-access.
        set_req(0, 0, 0, 1, 1);
        tick();
        set_req(1, 1, 0, 0, 0);
        ticks(4);
        set_req(0, 1, 0, 0, 0);
        ticks(6);
        set_req(0, 0, 0, 0, 0);
        ticks(8);

        // CPU drops its request during the first access cycle.
        set_req(0, 1, 1, 0, 0);
        tick();
        set_req(0, 0, 0, 0, 0);
        ticks(8);

        // Reset during a blitter write, released with both CPU and blitter requesting.
        set_req(0, 0, 0, 1, 1);
        tick();
        set_req(0, 1, 0, 1, 1);
        clr_n = 1'b0;
        ticks(2);
        clr_n = 1'b1;
        ticks(12);
        set_req(0, 0, 0, 0, 0);
        ticks(8);

        // All three requesting, then video drops away.
        set_req(1, 1, 0, 1, 0);
        ticks(8);
        set_req(0, 1, 1, 1, 0);
        ticks(12);
        set_req(0, 0, 0, 0, 0);
        ticks(8);

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 3000; k++) begin
            set_req($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 55,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 55,
                    $urandom_range(0, 1) == 1);
            clr_n = ($urandom_range(0, 299) != 0);
            tick();
            if (!clr_n) begin
                tick();
                clr_n = 1'b1;
            end
        end
        set_req(0, 0, 0, 0, 0);
        clr_n = 1'b1;
        ticks(12);

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Sequences access to the shared video RAM between the video scan fetch, the Z80 CPU and the blitter. Video fetch has absolute priority; the CPU and blitter share the remaining slots round-robin. The block issues one-hot grants, the RAM address/data mux select, the active-low RAM write strobe and the Z80 wait line. It sits between the CPU bus interface, the blitter and the video timing chain, ahead of the RAM mux logic.

## Interface
- ACC_CYC, 2, clock cycles per RAM access (legal 1..15)
- TURN, 1, dead cycles between consecutive grants (legal 0 or 1)

- CLK  in  1  system clock, rising-edge
- _CLR  in  1  asynchronous, active-low reset
- VID_REQ  in  1  video fetch request, level, read-only
- CPU_REQ  in  1  CPU access request, level
- CPU_WR  in  1  CPU access is a write (valid while CPU_REQ high)
- BLT_REQ  in  1  blitter access request, level
- BLT_WR  in  1  blitter access is a write (valid while BLT_REQ high)
- VID_GNT / CPU_GNT / BLT_GNT  out  1 each  grant, registered, at most one high
- SEL  out  2  mux select: 00 none, 01 video, 10 CPU, 11 blitter
- _WE  out  1  RAM write strobe, active-low
- ACK  out  1  one-cycle pulse in final access cycle
- _WAIT  out  1  Z80 wait, active-low

## Operation
- States: IDLE, ACCESS (cycle counter 1..ACC_CYC), RECOVER (only when TURN=1).
- Decision edge: any edge in IDLE, edge ending the last ACCESS cycle (TURN=0), or edge ending RECOVER (TURN=1). Requests are sampled only at decision edges.
- Priority at a decision edge: VID_REQ wins. Otherwise CPU vs blitter by round-robin pointer LAST: if both request, grant the one not equal to LAST. If only one requests, grant it.
- LAST updates to CPU or BLT whenever that requester is granted. Video grants leave LAST unchanged. Reset value: LAST = BLT, so the CPU wins the first tie.
- Exclusion: a requester whose ACK is high in the cycle ending at the decision edge is excluded from that decision. Its REQ is treated as stale.
- No request at a decision edge: go to IDLE with all grants low.
- No pre-emption: an ACCESS runs all ACC_CYC cycles even if video requests or the owner drops REQ mid-access. ACK still pulses in that case.
- Write strobe: _WE is low only in the final ACCESS cycle of a CPU or blitter grant whose WR bit was sampled high at the decision edge. WR is latched at grant; changes during the access are ignored. Video grants never assert _WE.
- _WAIT is combinational: low when CPU_REQ=1, unless CPU_GNT=1 and ACK=1.
- Reset (_CLR low, asynchronous, any time including mid-access):
  - state IDLE, counter 0, LAST=BLT;
  - all GNT 0, SEL 00, _WE 1, ACK 0.
  - _WAIT follows CPU_REQ (low if CPU_REQ=1).

## Timing
- Grant latency: request sampled at edge E, so GNT/SEL are high from E for exactly ACC_CYC cycles.
- ACK and any _WE low occur in the last of those cycles.
- TURN=0: the next grant starts on the cycle immediately after ACK. The bus is never idle while requests are pending.
- TURN=1: one cycle with all grants low and SEL=00 after each access.
- Requester rule: drop REQ or present a new access on the edge after ACK. A REQ still high one cycle after the exclusion decision counts as a new request.
- CPU/blitter worst-case wait, with continuous video requests, is unbounded. The video timing chain guarantees gaps.

## Test plan
- Reset, then single CPU write (ACC_CYC=2, TURN=1):
  - CPU_REQ=1, CPU_WR=1 sampled at edge 0 → CPU_GNT=1, SEL=10 on cycles 1–2.
  - ACK=1 and _WE=0 on cycle 2 only.
  - _WAIT low on cycle 0–1, high on cycle 2.
  - Cycle 3 all grants low.
- CPU and blitter requesting continuously (TURN=0): grant order CPU, BLT, CPU, BLT, each 2 cycles, with no gap cycles.
- Video priority:
  - BLT access in progress, VID_REQ and CPU_REQ rise mid-access → BLT completes.
  - Then VID granted (SEL=01, _WE stays 1), then CPU.
- Mid-access abort: CPU drops CPU_REQ in its first ACCESS cycle → access still spans ACC_CYC cycles with ACK. No second CPU grant follows.
- Reset mid-access: _CLR low in cycle 1 of a blitter write → same cycle BLT_GNT=0, SEL=00, _WE=1, ACK=0. After release with CPU_REQ and BLT_REQ both high, CPU is granted first.
- ACC_CYC=1, TURN=0, all three requesting continuously → VID every cycle. Drop VID_REQ → CPU and BLT alternate one cycle each, ACK high every cycle.
